// File: rtl/imem_boot_loader_pkg.sv
// Shared boot-loader definitions: memory geometry, loader FSM states
// and frame header size.
package defines;

    localparam int DATA_WIDTH          = 32;
    localparam int INST_MEM_DEPTH      = 256;
    localparam int INST_MEM_ADDR_WIDTH = $clog2(INST_MEM_DEPTH);
    localparam int BOOT_LEN_BYTES      = 2;

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } loader_state_t;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte stream in, instruction-memory write port out.
// Master drives the stream; the loader is the slave.
interface imem_boot_loader_if #(
    parameter int BYTE_WIDTH = 8
);

    logic                                     rx_valid_i;
    logic [BYTE_WIDTH-1:0]                    rx_data_i;
    logic                                     rx_ready_o;
    logic                                     imem_we_o;
    logic [defines::INST_MEM_ADDR_WIDTH-1:0]  imem_waddr_o;
    logic [defines::DATA_WIDTH-1:0]           imem_wdata_o;

    modport master (
        output rx_valid_i,
        output rx_data_i,
        input  rx_ready_o,
        input  imem_we_o,
        input  imem_waddr_o,
        input  imem_wdata_o
    );

    modport slave (
        input  rx_valid_i,
        input  rx_data_i,
        output rx_ready_o,
        output imem_we_o,
        output imem_waddr_o,
        output imem_wdata_o
    );

endinterface

// File: rtl/imem_boot_loader_packer.sv
// Little-endian byte-to-word packer; word_ready fires with the
// fourth byte, and word already includes that byte.
module imem_byte_packer #(
    parameter int BYTE_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    en,
    input  logic [BYTE_WIDTH-1:0]   data,
    output logic [4*BYTE_WIDTH-1:0] word,
    output logic                    word_ready
);

    logic [1:0]              idx;
    logic [3*BYTE_WIDTH-1:0] sh;

    assign word       = {data, sh};
    assign word_ready = en && (idx == 2'd3);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            idx <= '0;
            sh  <= '0;
        end else if (en) begin
            idx <= idx + 2'd1;
            sh  <= {data, sh[3*BYTE_WIDTH-1:BYTE_WIDTH]};
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Length-prefixed boot image loader into instruction memory.
// Define BOOT_CHECKSUM_EN to require a trailing mod-256 checksum byte.
module imem_boot_loader
    import defines::*;
#(
    parameter int BYTE_WIDTH = 8,
    parameter int MAX_WORDS  = INST_MEM_DEPTH
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    imem_boot_loader_if.slave   bus,
    input  logic                load_req_i,
    output logic                core_hold_o,
    output logic                done_o,
    output logic                err_o
);

    loader_state_t                  state;
    logic [BYTE_WIDTH-1:0]          len_lo;
    logic [15:0]                    len;
    logic [15:0]                    word_cnt;
    logic [15:0]                    n_rx;
    logic                           len_bad;
    logic                           last_word;
    logic                           xfer;
    logic                           pk_en;
    logic                           pk_clr;
    logic [4*BYTE_WIDTH-1:0]        pk_word;
    logic                           pk_ready;
    logic                           we_q;
    logic [INST_MEM_ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0]          wdata_q;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]                     acc;
    logic                           csum_ok;
`endif

    assign bus.rx_ready_o = rst_n_i &&
        (state inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM});
    assign xfer      = bus.rx_valid_i && bus.rx_ready_o;
    assign n_rx      = 16'({bus.rx_data_i, len_lo});
    assign len_bad   = (n_rx == 16'd0) || (int'(n_rx) > MAX_WORDS);
    assign last_word = (word_cnt == len - 16'd1);
`ifdef BOOT_CHECKSUM_EN
    assign csum_ok   = (8'(acc + 8'(bus.rx_data_i)) == 8'd0);
`endif

    assign pk_en  = xfer && (state == S_DATA);
    assign pk_clr = (state != S_DATA);

    imem_byte_packer #(
        .BYTE_WIDTH(BYTE_WIDTH)
    ) u_packer (
        .clk       (clk_i),
        .rst_n     (rst_n_i),
        .clr       (pk_clr),
        .en        (pk_en),
        .data      (bus.rx_data_i),
        .word      (pk_word),
        .word_ready(pk_ready)
    );

    assign bus.imem_we_o    = we_q;
    assign bus.imem_waddr_o = waddr_q;
    assign bus.imem_wdata_o = wdata_q;

    assign core_hold_o = (state != S_DONE);
    assign done_o      = (state == S_DONE);
    assign err_o       = (state == S_ERR);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state    <= S_LEN_LO;
            len_lo   <= '0;
            len      <= '0;
            word_cnt <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
`ifdef BOOT_CHECKSUM_EN
            acc      <= '0;
`endif
        end else begin
            we_q <= pk_ready;
            if (pk_ready) begin
                waddr_q <= word_cnt[INST_MEM_ADDR_WIDTH-1:0];
                wdata_q <= DATA_WIDTH'(pk_word);
            end
            unique case (state)
                S_LEN_LO: begin
                    if (xfer) begin
                        len_lo <= bus.rx_data_i;
                        state  <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (xfer) begin
                        len      <= n_rx;
                        word_cnt <= '0;
`ifdef BOOT_CHECKSUM_EN
                        acc      <= '0;
`endif
                        // bad lengths are rejected before any write
                        state    <= len_bad ? S_ERR : S_DATA;
                    end
                end
                S_DATA: begin
`ifdef BOOT_CHECKSUM_EN
                    if (xfer) acc <= acc + 8'(bus.rx_data_i);
`endif
                    if (pk_ready) begin
                        word_cnt <= word_cnt + 16'd1;
                        if (last_word) begin
`ifdef BOOT_CHECKSUM_EN
                            state <= S_CSUM;
`else
                            state <= S_DONE;
`endif
                        end
                    end
                end
`ifdef BOOT_CHECKSUM_EN
                S_CSUM: begin
                    if (xfer) state <= csum_ok ? S_DONE : S_ERR;
                end
`endif
                S_DONE, S_ERR: begin
                    if (load_req_i) begin
                        state    <= S_LEN_LO;
                        word_cnt <= '0;
                    end
                end
                default: state <= S_LEN_LO;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized self-checking bench for imem_boot_loader against a
// frame-level model of the expected memory writes.
module tb_imem_boot_loader;
    import defines::*;

    typedef logic [7:0]  bq_t[$];
    typedef logic [31:0] wl_t[$];
    typedef struct {
        int          addr;
        logic [31:0] data;
        logic        done;
        logic        hold;
        int          cyc;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load_req = 1'b0;
    logic hold, done, err;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    wr_t  wq[$];
    logic [31:0] mem_seen[int];

    imem_boot_loader_if #(.BYTE_WIDTH(8)) bus();

    imem_boot_loader dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .bus        (bus),
        .load_req_i (load_req),
        .core_hold_o(hold),
        .done_o     (done),
        .err_o      (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.imem_we_o === 1'b1) begin
            wq.push_back('{addr: int'(bus.imem_waddr_o),
                           data: bus.imem_wdata_o,
                           done: done, hold: hold, cyc: cyc});
            mem_seen[int'(bus.imem_waddr_o)] = bus.imem_wdata_o;
        end
    end

    // Frame model: header, little-endian payload, optional checksum.
    function automatic bq_t build_frame(input wl_t w, input bit good);
        bq_t q;
        logic [7:0] s = 8'd0;
        q.push_back(8'(w.size()));
        q.push_back(8'(w.size() >> 8));
        foreach (w[i]) begin
            for (int k = 0; k < 4; k++) begin
                q.push_back(w[i][8*k +: 8]);
                s = s + w[i][8*k +: 8];
            end
        end
`ifdef BOOT_CHECKSUM_EN
        q.push_back(good ? 8'(-s) : 8'(-s - 8'd1));
`else
        if (!good) q.push_back(8'h00);
`endif
        return q;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reload();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int budget = 0;
        repeat (gap) tick();
        bus.rx_valid_i = 1'b1;
        bus.rx_data_i  = b;
        @(negedge clk);
        while (bus.rx_ready_o !== 1'b1 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout ready stuck at %b, need 1",
                     bus.rx_ready_o);
        end
        tick();
        bus.rx_valid_i = 1'b0;
    endtask

    task automatic send_frame(input bq_t q, input int max_gap);
        foreach (q[i]) send_byte(q[i], $urandom_range(max_gap, 0));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.rx_valid_i = 1'b0;
        bus.rx_data_i  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.imem_we_o !== 1'b0) begin
            errors++; $display("FAIL reset_we got %b want 0", bus.imem_we_o);
        end
        checks++;
        if (bus.imem_waddr_o !== '0) begin
            errors++; $display("FAIL reset_waddr got %h want 0", bus.imem_waddr_o);
        end
        checks++;
        if (bus.imem_wdata_o !== '0) begin
            errors++; $display("FAIL reset_wdata got %h want 0", bus.imem_wdata_o);
        end
        checks++;
        if (hold !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_status got h%b d%b e%b want h1 d0 e0",
                     hold, done, err);
        end
        checks++;
        if (bus.rx_ready_o !== 1'b0) begin
            errors++; $display("FAIL reset_ready got %b want 0", bus.rx_ready_o);
        end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.rx_ready_o !== 1'b1 || hold !== 1'b1) begin
            errors++;
            $display("FAIL post_reset got rdy%b h%b want rdy1 h1",
                     bus.rx_ready_o, hold);
        end
        tick();
    endtask

    task automatic test_basic();
        wl_t w = '{32'h12345678, 32'hDEADBEEF};
        wq.delete();
        send_frame(build_frame(w, 1'b1), 0);
        @(negedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || hold !== 1'b0) begin
            errors++;
            $display("FAIL basic_done got d%b h%b want d1 h0", done, hold);
        end
        checks++;
        if (wq.size() != 2) begin
            errors++; $display("FAIL basic_count got %0d want 2", wq.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (wq[i].addr != i || wq[i].data !== w[i]) begin
                    errors++;
                    $display("FAIL basic_wr%0d got %0d:%h want %0d:%h",
                             i, wq[i].addr, wq[i].data, i, w[i]);
                end
            end
            checks++;
            if (wq[1].cyc - wq[0].cyc != 4) begin
                errors++;
                $display("FAIL basic_spacing got %0d want 4",
                         wq[1].cyc - wq[0].cyc);
            end
`ifndef BOOT_CHECKSUM_EN
            checks++;
            if (wq[1].done !== 1'b1 || wq[1].hold !== 1'b0 ||
                wq[0].done !== 1'b0) begin
                errors++;
                $display("FAIL basic_release got d%b h%b want d1 h0",
                         wq[1].done, wq[1].hold);
            end
`endif
        end
        tick();
    endtask

    task automatic test_reload();
        wl_t w;
        w.push_back($urandom);
        reload();
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || hold !== 1'b1 || bus.rx_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reload_state got d%b h%b r%b want d0 h1 r1",
                     done, hold, bus.rx_ready_o);
        end
        tick();
        wq.delete();
        send_frame(build_frame(w, 1'b1), 0);
        @(negedge clk);
        #1;
        checks++;
        if (wq.size() != 1 || wq[0].addr != 0 || wq[0].data !== w[0]) begin
            errors++;
            $display("FAIL reload_write got n%0d want 1 write of %h at 0",
                     wq.size(), w[0]);
        end
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL reload_done got %b want 1", done);
        end
        tick();
    endtask

    task automatic test_len_err();
        int lens[3];
        lens[0] = 0;
        lens[1] = INST_MEM_DEPTH + 1;
        lens[2] = $urandom_range(65535, INST_MEM_DEPTH + 2);
        foreach (lens[i]) begin
            reload();
            wq.delete();
            send_byte(8'(lens[i]), 0);
            send_byte(8'(lens[i] >> 8), 0);
            @(negedge clk);
            checks++;
            if (err !== 1'b1 || hold !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL len_err_%0d got e%b h%b d%b want e1 h1 d0",
                         lens[i], err, hold, done);
            end
            repeat (3) @(posedge clk);
            @(negedge clk);
            #1;
            checks++;
            if (wq.size() != 0 || bus.rx_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL len_err_nowr_%0d got n%0d r%b want n0 r0",
                         lens[i], wq.size(), bus.rx_ready_o);
            end
            tick();
        end
    endtask

    task automatic test_gaps();
        for (int f = 0; f < 5; f++) begin
            wl_t w;
            int n = (f == 0) ? 4 : $urandom_range(8, 1);
            for (int i = 0; i < n; i++) w.push_back($urandom);
            reload();
            wq.delete();
            send_frame(build_frame(w, 1'b1), 5);
            @(negedge clk);
            #1;
            checks++;
            if (wq.size() != n || done !== 1'b1) begin
                errors++;
                $display("FAIL gaps_f%0d got n%0d d%b want n%0d d1",
                         f, wq.size(), done, n);
            end else begin
                foreach (w[i]) begin
                    checks++;
                    if (wq[i].addr != i || wq[i].data !== w[i]) begin
                        errors++;
                        $display("FAIL gaps_f%0d_w%0d got %0d:%h want %0d:%h",
                                 f, i, wq[i].addr, wq[i].data, i, w[i]);
                    end
                end
            end
            tick();
        end
    endtask

`ifdef BOOT_CHECKSUM_EN
    task automatic test_checksum();
        wl_t w = '{32'h04030201};
        reload();
        send_frame(build_frame(w, 1'b1), 0);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL csum_good got d%b e%b want d1 e0", done, err);
        end
        tick();
        reload();
        send_frame(build_frame(w, 1'b0), 0);
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || hold !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL csum_bad got e%b h%b d%b want e1 h1 d0",
                     err, hold, done);
        end
        tick();
    endtask
`endif

    task automatic test_reset_mid();
        wl_t w  = '{32'h0, 32'h0};
        wl_t w2 = '{32'h0};
        bq_t q;
        w[0]  = $urandom;
        w[1]  = $urandom;
        w2[0] = $urandom;
        q = build_frame(w, 1'b1);
        reload();
        wq.delete();
        for (int i = 0; i < BOOT_LEN_BYTES + 5; i++) send_byte(q[i], 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        send_frame(build_frame(w2, 1'b1), 0);
        @(negedge clk);
        #1;
        checks++;
        if (wq.size() != 2) begin
            errors++; $display("FAIL rstmid_count got %0d want 2", wq.size());
        end else begin
            checks++;
            if (wq[0].addr != 0 || wq[0].data !== w[0]) begin
                errors++;
                $display("FAIL rstmid_first got %0d:%h want 0:%h",
                         wq[0].addr, wq[0].data, w[0]);
            end
            checks++;
            if (wq[1].addr != 0 || wq[1].data !== w2[0]) begin
                errors++;
                $display("FAIL rstmid_new got %0d:%h want 0:%h",
                         wq[1].addr, wq[1].data, w2[0]);
            end
        end
        checks++;
        if (done !== 1'b1 || mem_seen[0] !== w2[0]) begin
            errors++;
            $display("FAIL rstmid_done got d%b m%h want d1 m%h",
                     done, mem_seen[0], w2[0]);
        end
        tick();
    endtask

    initial begin
        bus.rx_valid_i = 1'b0;
        bus.rx_data_i  = 8'h00;
        test_reset();
        test_basic();
        test_reload();
        test_len_err();
        test_gaps();
`ifdef BOOT_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout reached at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
